// File: rtl/bcd_conv_arb.sv
// Round-robin arbiter that shares one binary-to-BCD pipeline between NREQ requesters.
// Optional BCD_ARB_SAT_EN: clamp issued values above 999 and flag them on res_err.
module bcd_conv_arb #(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NREQ-1:0]      req,
  input  logic [10*NREQ-1:0]   bin_in,
  output logic [NREQ-1:0]      gnt,
  output logic [9:0]           pipe_bin,
  output logic                 pipe_vld,
  input  logic [16:0]          pipe_bcd_r,
  input  logic                 pipe_vld_r,
  output logic [16:0]          res_bcd,
  output logic [IDW-1:0]       res_id,
  output logic                 res_vld,
  output logic                 res_err,
  output logic                 idle,
  output logic                 sync_err
);
  localparam int CW = $clog2(LAT + 2);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t         state_r;
  logic [IDW-1:0] ptr_r;
  logic [IDW-1:0] gidx_s;
  logic           any_gnt_s;
  logic           retire_s;
  logic [9:0]     raw_bin_s;
  logic [9:0]     issue_bin_s;
  logic           issue_err_s;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  cnt_nxt_s;
  logic           tag_vld_r [0:LAT];
  logic [IDW-1:0] tag_id_r  [0:LAT];
  logic           tag_err_r [0:LAT];
  logic [9:0]     issue_bin_r;
  logic           issue_vld_r;
  logic [16:0]    res_bcd_r;
  logic [IDW-1:0] res_id_r;
  logic           res_vld_r;
  logic           res_err_r;
  logic           idle_r;
  logic           sync_err_r;

  function automatic int rr_idx(input logic [IDW-1:0] p, input int k);
    return (int'(p) + k) % NREQ;
  endfunction

  // Round-robin search: walk downward so the lowest offset from ptr_r wins.
  always_comb begin
    gidx_s = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      gidx_s = req[IDW'(rr_idx(ptr_r, k))] ? IDW'(rr_idx(ptr_r, k)) : gidx_s;
    end
  end

  assign any_gnt_s = en && !rst && (|req);
  assign gnt       = any_gnt_s ? (NREQ'(1) << gidx_s) : '0;
  assign retire_s  = tag_vld_r[LAT];
  assign cnt_nxt_s = cnt_r + CW'(any_gnt_s) - CW'(retire_s);

  // Select the granted requester's 10-bit slice.
  always_comb begin
    raw_bin_s = 10'd0;
    for (int k = 0; k < NREQ; k++) begin
      raw_bin_s = raw_bin_s | ((gidx_s == IDW'(k)) ? bin_in[10*k +: 10] : 10'd0);
    end
  end

`ifdef BCD_ARB_SAT_EN
  assign issue_err_s = (raw_bin_s > 10'd999);
  assign issue_bin_s = issue_err_s ? 10'd999 : raw_bin_s;
`else
  assign issue_err_s = 1'b0;
  assign issue_bin_s = raw_bin_s;
`endif

  // Issue, tag tracking, retirement, sequencing state and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      ptr_r       <= '0;
      cnt_r       <= '0;
      issue_bin_r <= 10'd0;
      issue_vld_r <= 1'b0;
      res_bcd_r   <= 17'd0;
      res_id_r    <= '0;
      res_vld_r   <= 1'b0;
      res_err_r   <= 1'b0;
      idle_r      <= 1'b1;
      sync_err_r  <= 1'b0;
      for (int i = 0; i <= LAT; i++) begin
        tag_vld_r[i] <= 1'b0;
        tag_id_r[i]  <= '0;
        tag_err_r[i] <= 1'b0;
      end
    end else begin
      issue_vld_r <= any_gnt_s;
      if (any_gnt_s) begin
        issue_bin_r <= issue_bin_s;
        ptr_r       <= (gidx_s == IDW'(NREQ - 1)) ? '0 : gidx_s + IDW'(1);
      end else begin
        issue_bin_r <= issue_bin_r;
        ptr_r       <= ptr_r;
      end

      tag_vld_r[0] <= any_gnt_s;
      tag_id_r[0]  <= gidx_s;
      tag_err_r[0] <= issue_err_s;
      for (int i = 1; i <= LAT; i++) begin
        tag_vld_r[i] <= tag_vld_r[i-1];
        tag_id_r[i]  <= tag_id_r[i-1];
        tag_err_r[i] <= tag_err_r[i-1];
      end

      res_vld_r <= retire_s && pipe_vld_r;
      if (retire_s && pipe_vld_r) begin
        res_bcd_r <= pipe_bcd_r;
        res_id_r  <= tag_id_r[LAT];
        res_err_r <= tag_err_r[LAT];
      end else begin
        res_bcd_r <= res_bcd_r;
        res_id_r  <= res_id_r;
        res_err_r <= res_err_r;
      end

      // A result without a tag, or a tag without a result, means the pipeline lost sync.
      sync_err_r <= sync_err_r | (retire_s ^ pipe_vld_r);
      cnt_r      <= cnt_nxt_s;
      idle_r     <= (cnt_r == '0) && !any_gnt_s;

      case (state_r)
        S_IDLE:  state_r <= any_gnt_s ? S_RUN : S_IDLE;
        S_RUN: begin
          if (!en) begin
            state_r <= (cnt_nxt_s != '0) ? S_DRAIN : S_IDLE;
          end else begin
            state_r <= ((cnt_nxt_s == '0) && !any_gnt_s) ? S_IDLE : S_RUN;
          end
        end
        S_DRAIN: state_r <= any_gnt_s ? S_RUN : ((cnt_nxt_s == '0) ? S_IDLE : S_DRAIN);
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign pipe_bin = issue_bin_r;
  assign pipe_vld = issue_vld_r;
  assign res_bcd  = res_bcd_r;
  assign res_id   = res_id_r;
  assign res_vld  = res_vld_r;
  assign res_err  = res_err_r;
  assign idle     = idle_r;
  assign sync_err = sync_err_r;

endmodule

// File: tb/tb_bcd_conv_arb.sv
// Bench for bcd_conv_arb: stand-in conversion pipeline, queue-based reference model,
// vector table and directed corner sequences. Honours BCD_ARB_SAT_EN if defined.
module tb_bcd_conv_arb;
  localparam int NREQ = 4;
  localparam int LAT  = 3;
  localparam int IDW  = 2;
`ifdef BCD_ARB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [10*NREQ-1:0] bin_in = '0;
  logic              inj = 1'b0;
  logic [NREQ-1:0]   gnt;
  logic [9:0]        pipe_bin;
  logic              pipe_vld;
  logic [16:0]       pipe_bcd_r;
  logic              pipe_vld_r;
  logic [16:0]       res_bcd;
  logic [IDW-1:0]    res_id;
  logic              res_vld;
  logic              res_err;
  logic              idle;
  logic              sync_err;

  logic              st_vld [LAT];
  logic [16:0]       st_bcd [LAT];

  bcd_conv_arb #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .bin_in(bin_in), .gnt(gnt),
    .pipe_bin(pipe_bin), .pipe_vld(pipe_vld), .pipe_bcd_r(pipe_bcd_r),
    .pipe_vld_r(pipe_vld_r), .res_bcd(res_bcd), .res_id(res_id), .res_vld(res_vld),
    .res_err(res_err), .idle(idle), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] to_bcd(input int v);
    return 17'((v / 1000) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
  endfunction

  // Stand-in conversion pipeline of depth LAT; inj forces a stray result strobe.
  assign pipe_vld_r = st_vld[LAT-1] | inj;
  assign pipe_bcd_r = st_bcd[LAT-1];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        st_vld[i] <= 1'b0;
        st_bcd[i] <= 17'd0;
      end
    end else begin
      st_vld[0] <= pipe_vld;
      st_bcd[0] <= to_bcd(int'(pipe_bin));
      for (int i = 1; i < LAT; i++) begin
        st_vld[i] <= st_vld[i-1];
        st_bcd[i] <= st_bcd[i-1];
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct { int id; int bcd; int err; int due; } exp_t;
  exp_t exp_q[$];
  exp_t m_e;
  int   m_ptr = 0;
  int   m_cyc = 0;
  int   m_pick;
  int   m_v;
  bit   m_hit;
  bit   chk_on = 1'b0;
  bit   e_pvld = 1'b0;
  int   e_pbin = 0;
  bit   e_idle = 1'b1;
  bit   e_sync = 1'b0;

  function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // Per-cycle scoreboard: check this cycle's outputs, then advance the model.
  always @(negedge clk) begin
    m_cyc++;
    m_pick = (rst || !en) ? -1 : model_pick(req, m_ptr);
    if (chk_on) begin
      chk("pipe_vld", int'(pipe_vld), int'(e_pvld));
      if (e_pvld) chk("pipe_bin", int'(pipe_bin), e_pbin);
      m_hit = (exp_q.size() > 0) && (exp_q[0].due == m_cyc);
      chk("res_vld", int'(res_vld), int'(m_hit));
      if (m_hit) begin
        m_e = exp_q.pop_front();
        chk("res_id", int'(res_id), m_e.id);
        chk("res_bcd", int'(res_bcd), m_e.bcd);
        chk("res_err", int'(res_err), m_e.err);
      end
      chk("idle", int'(idle), int'(e_idle));
      chk("sync_err", int'(sync_err), int'(e_sync));
      chk("gnt", int'(gnt), (m_pick < 0) ? 0 : (1 << m_pick));
    end
    if (rst) begin
      exp_q.delete();
      m_ptr  = 0;
      e_pvld = 1'b0;
      e_pbin = 0;
      e_idle = 1'b1;
      e_sync = 1'b0;
      chk_on = 1'b1;
    end else if (chk_on) begin
      e_idle = (exp_q.size() == 0) && (m_pick < 0);
      if (inj) e_sync = 1'b1;
      e_pvld = (m_pick >= 0);
      if (m_pick >= 0) begin
        m_v    = int'(bin_in[10*m_pick +: 10]);
        m_e.err = (SAT && m_v > 999) ? 1 : 0;
        if (m_e.err == 1) m_v = 999;
        e_pbin  = m_v;
        m_e.id  = m_pick;
        m_e.bcd = int'(to_bcd(m_v));
        m_e.due = m_cyc + LAT + 2;
        exp_q.push_back(m_e);
        m_ptr = (m_pick + 1) % NREQ;
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct { logic en; logic [NREQ-1:0] req; logic [NREQ-1:0] exp_gnt; } vec_t;
  vec_t tbl [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req = '0; inj = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_res(output int n);
    n = 0;
    while (n < 12 && !res_vld) begin
      step();
      #2;
      n++;
    end
  endtask

  int n_vld;
  int lat_k;
  bit prev_vld;
  logic [NREQ-1:0] g;

  initial begin
    tbl[0]  = '{1'b1, 4'b0100, 4'b0100};
    tbl[1]  = '{1'b1, 4'b0101, 4'b0001};
    tbl[2]  = '{1'b1, 4'b0101, 4'b0100};
    tbl[3]  = '{1'b0, 4'b1111, 4'b0000};
    tbl[4]  = '{1'b1, 4'b1111, 4'b1000};
    tbl[5]  = '{1'b1, 4'b1111, 4'b0001};
    tbl[6]  = '{1'b1, 4'b0000, 4'b0000};
    tbl[7]  = '{1'b1, 4'b0001, 4'b0001};
    tbl[8]  = '{1'b1, 4'b1010, 4'b0010};
    tbl[9]  = '{1'b1, 4'b1010, 4'b1000};
    tbl[10] = '{1'b1, 4'b0110, 4'b0010};
    tbl[11] = '{1'b1, 4'b0110, 4'b0100};

    // Reset values
    do_reset();
    #2;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_pipe_vld", int'(pipe_vld), 0);
    chk("rst_pipe_bin", int'(pipe_bin), 0);
    chk("rst_res_vld", int'(res_vld), 0);
    chk("rst_res_bcd", int'(res_bcd), 0);
    chk("rst_res_id", int'(res_id), 0);
    chk("rst_res_err", int'(res_err), 0);
    chk("rst_idle", int'(idle), 1);
    chk("rst_sync_err", int'(sync_err), 0);
    step();

    // Single request: grant, issue next cycle, result LAT+2 cycles after grant
    en = 1'b1; req = 4'b0100; bin_in[29:20] = 10'd347;
    #2 chk("single_gnt", int'(gnt), 4);
    step();
    req = '0;
    #2 chk("single_pipe_bin", int'(pipe_bin), 347);
    lat_k = 1;
    while (lat_k < 10 && !res_vld) begin
      step();
      #2;
      lat_k++;
    end
    chk("single_lat", lat_k, LAT + 2);
    chk("single_id", int'(res_id), 2);
    chk("single_bcd", int'(res_bcd), 'h347);
    chk("single_err", int'(res_err), 0);
    step();

    // Arbitration table from a fresh pointer
    do_reset();
    for (int i = 0; i < 12; i++) begin
      en = tbl[i].en; req = tbl[i].req;
      bin_in = 40'({$urandom(), $urandom()});
      #2 chk("tbl_gnt", int'(gnt), int'(tbl[i].exp_gnt));
      step();
    end
    req = '0;
    for (int i = 0; i < 8; i++) step();

    // All four requesting continuously
    do_reset();
    en = 1'b1; req = 4'b1111;
    bin_in = {10'd400, 10'd300, 10'd200, 10'd100};
    for (int k = 0; k < 12; k++) begin
      #2 chk("stream_gnt", int'(gnt), 1 << (k % 4));
      if (k > 0) chk("stream_idle", int'(idle), 0);
      step();
    end
    req = '0;
    for (int i = 0; i < 8; i++) step();

    // Drain: three grants, then en falls
    do_reset();
    en = 1'b1; req = 4'b1111;
    for (int i = 0; i < 3; i++) step();
    en = 1'b0;
    n_vld = 0; prev_vld = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #2 chk("drain_gnt", int'(gnt), 0);
      if (n_vld == 3 && prev_vld && !res_vld) chk("drain_idle", int'(idle), 1);
      if (res_vld) n_vld++;
      prev_vld = res_vld;
      step();
    end
    chk("drain_count", n_vld, 3);
    req = '0;

    // Out-of-range value
    do_reset();
    en = 1'b1; req = 4'b0001; bin_in[9:0] = 10'd1023;
    #2 chk("sat_gnt", int'(gnt), 1);
    step();
    req = '0;
    #2 chk("sat_pipe_bin", int'(pipe_bin), SAT ? 999 : 1023);
    wait_res(lat_k);
    chk("sat_res_vld", int'(res_vld), 1);
    chk("sat_res_err", int'(res_err), SAT ? 1 : 0);
    chk("sat_res_bcd", int'(res_bcd), SAT ? 'h999 : 'h1023);
    step();

    // Stray pipeline result
    do_reset();
    step();
    inj = 1'b1;
    step();
    inj = 1'b0;
    #2 chk("sync_set", int'(sync_err), 1);
    chk("sync_no_res", int'(res_vld), 0);
    for (int i = 0; i < 3; i++) step();
    #2 chk("sync_sticky", int'(sync_err), 1);
    do_reset();
    #2 chk("sync_clear", int'(sync_err), 0);
    step();

    // Reset with two conversions in flight
    do_reset();
    en = 1'b1; req = 4'b0011; bin_in = 40'({$urandom(), $urandom()});
    step();
    step();
    req = '0; en = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    #2 chk("mid_pipe_vld", int'(pipe_vld), 0);
    chk("mid_idle", int'(idle), 1);
    n_vld = 0;
    for (int i = 0; i < 8; i++) begin
      if (res_vld) n_vld++;
      step();
      #2;
    end
    chk("mid_no_res", n_vld, 0);
    en = 1'b1; req = 4'b1111;
    #1 chk("mid_ptr0", int'(gnt), 1);
    step();
    req = '0;
    for (int i = 0; i < 8; i++) step();

    // Randomised traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      #2 g = gnt;
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!(req[i] && !g[i])) begin
          req[i] = 1'($urandom_range(0, 1));
          bin_in[10*i +: 10] = 10'($urandom_range(0, 1023));
        end
      end
      en = ($urandom_range(0, 9) != 0);
    end
    req = '0; en = 1'b0;
    for (int i = 0; i < 10; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arb.md
# bcd_conv_arb

Round-robin arbiter and sequencer that shares one binary-to-BCD conversion pipeline between NREQ requesters (display channels). It accepts a 10-bit binary value per request and issues at most one value per cycle into the pipeline. It tracks each issued value's requester ID through the pipeline latency and returns the 17-bit BCD result tagged with that ID. It sits between the display-channel logic and the hundreds/tens/units pipeline stages.

## Interface
- NREQ, 4, number of requesters (2..8).
- LAT, 3, fixed latency of the conversion pipeline in cycles (pipe_vld to pipe_vld_r), 1..8.
- IDW, 2, width of the requester ID, clog2(NREQ).

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- en  in  1  1 = new grants allowed; 0 = drain.
- req  in  NREQ  per-requester request level.
- bin_in  in  10*NREQ  request values; requester i uses bits [10i+9:10i].
- gnt  out  NREQ  one-hot accept strobe (combinational).
- pipe_bin  out  10  value to the pipeline (registered).
- pipe_vld  out  1  pipe_bin valid (registered).
- pipe_bcd_r  in  17  pipeline result.
- pipe_vld_r  in  1  pipeline result valid.
- res_bcd  out  17  returned BCD result (registered).
- res_id  out  IDW  requester that owns res_bcd.
- res_vld  out  1  one-cycle result strobe.
- res_err  out  1  value was out of range (>999); see Configuration.
- idle  out  1  no in-flight conversions and no grant this cycle.
- sync_err  out  1  sticky: pipeline returned a result with no matching tag, or a tag expired with no result.

## Operation
- States: IDLE (0 in flight), RUN (en=1, conversions in flight or being issued), DRAIN (en=0, in flight >0). DRAIN goes to IDLE when the last tag retires. RUN goes to DRAIN when en falls. IDLE or DRAIN go to RUN when en=1 and any req is high.
- Arbitration: when en=1 and any req is high, gnt asserts for the first requester at or after ptr, searching upward with wrap. The transfer happens at that clock edge. ptr then becomes (granted index + 1) mod NREQ. With no grant, ptr holds.
- Requester i must hold req[i] and its bin_in slice stable until the edge where gnt[i]=1. It may keep req high for back-to-back requests; the round-robin guarantees other requesters are served between its grants.
- Tag pipe: LAT+1 entries, each {valid, id, err}. Each cycle it shifts by one. The entry is written on a grant.
- Retire: when the tag at depth LAT (aligned with pipe_vld_r) is valid:
  - If pipe_vld_r=1, the block registers res_bcd=pipe_bcd_r, res_id=tag id, res_err=tag err, and pulses res_vld.
  - If pipe_vld_r=0, it sets sync_err and drops the tag.
- A pipe_vld_r with no valid tag sets sync_err and is dropped.
- In-flight count: +1 on grant, −1 on retire. Both in the same cycle leaves it unchanged.
- Reset values: gnt=0, pipe_bin=0, pipe_vld=0, res_bcd=0, res_id=0, res_vld=0, res_err=0, idle=1, sync_err=0, ptr=0, all tags invalid, state IDLE.
- Reset mid-operation: all in-flight tags are discarded and no res_vld is produced for them. The pipeline shares the same reset, so no stray pipe_vld_r follows.
- sync_err clears only on rst.

## Timing
- Grant edge N (gnt high in cycle N): pipe_bin/pipe_vld valid in cycle N+1.
- pipe_vld_r returns in N+1+LAT. res_vld is high in N+2+LAT, so request-to-result latency is LAT+2 (5 cycles at default).
- Throughput: one grant per cycle, sustained indefinitely; no backpressure on results.
- en falling in cycle N blocks grants in cycle N. In-flight results still return.
- idle=1 in the cycle after the last res_vld when no grant is pending.

## Configuration
- BCD_ARB_SAT_EN defined:
  - A granted value >999 is clamped to 999 before issue.
  - Its tag err bit is set, so res_err=1 alongside its res_vld.
- Undefined:
  - The value passes unmodified; the pipeline result for it is undefined by contract.
  - res_err is tied 0.

## Test plan
- Single request: after reset, req[2]=1, bin_in[2]=10'd347, en=1 -> gnt=4'b0100 in that cycle; pipe_bin=347 next cycle; 5 cycles after grant res_vld=1, res_id=2, res_bcd from pipeline (0x347 layout), res_err=0.
- All four requesting continuously with values 100/200/300/400 -> grants 0,1,2,3,0,... every cycle; results return in the same order with matching res_id; one grant per cycle; idle=0 throughout.
- Drain: start 3 back-to-back grants, drop en the next cycle -> no further gnt; 3 res_vld follow; idle=1 one cycle after the last; state returns to IDLE.
- Saturation: bin_in=10'd1023 -> with BCD_ARB_SAT_EN, pipe_bin=999 and res_err=1 with its result; without the macro, pipe_bin=1023 and res_err=0.
- Sync fault: inject pipe_vld_r=1 with no outstanding tag -> sync_err=1 next cycle, no res_vld, and sync_err stays high until rst.
- Reset mid-flight: assert rst with 2 conversions in flight -> all outputs go to reset values next cycle, no res_vld for the 2 lost conversions, ptr=0 on the first grant after reset.
